// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Also holds the fault predicate used by the optional IMEM_ARB_ERR_CHECK_EN build.
package imem_arb_pkg;

    localparam int ADDR_W_DEF    = 6;
    localparam int DATA_W_DEF    = 32;
    localparam int MEM_BYTES_DEF = 51;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    typedef enum logic {
        REQ_IF = 1'b0,
        REQ_LS = 1'b1
    } req_id_t;

    // A word access faults when it is misaligned or its last byte lies past the memory.
    function automatic logic addr_faults(input int addr, input int mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > mem_bytes - 4);
    endfunction

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Bundle of requester handshakes and the memory port seen by imem_port_arbiter.
// slave = arbiter side, master = requesters plus memory side.
interface imem_port_arbiter_if
    import imem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              ls_req;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;
    logic              ls_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, ls_req, ls_addr, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, if_err,
        output ls_gnt, ls_rvalid, ls_rdata, ls_err,
        output mem_addr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_addr, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, if_err,
        input  ls_gnt, ls_rvalid, ls_rdata, ls_err,
        input  mem_addr
    );

endinterface

// File: rtl/imem_port_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; bit 0 is IF, bit 1 is LS.
// The parent stores last_winner so this block stays stateless.
module rr_arb2
    import imem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    last_winner,
    output logic [1:0] gnt,
    output req_id_t    winner
);

    always_comb begin
        winner = REQ_IF;
        gnt    = 2'b00;
        case (req)
            2'b01:   winner = REQ_IF;
            2'b10:   winner = REQ_LS;
            2'b11:   winner = (last_winner == REQ_IF) ? REQ_LS : REQ_IF;
            default: winner = REQ_IF;
        endcase
        if (req != 2'b00) begin
            gnt = (winner == REQ_LS) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous-read memory port between fetch (IF) and load/store (LS),
// one access in flight, round-robin. Define IMEM_ARB_ERR_CHECK_EN for alignment/range faults.
module imem_port_arbiter
    import imem_arb_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    imem_port_arbiter_if.slave   bus
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    req_id_t           owner_q;
    req_id_t           last_winner_q;
    logic              err_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] ls_rdata_q;

    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;
    req_id_t           winner;
    logic [ADDR_W-1:0] win_addr;
    logic              win_fault;
    logic              accept;
    logic [DATA_W-1:0] resp_data;

    assign arb_req = {bus.ls_req, bus.if_req};

    rr_arb2 u_rr_arb2 (
        .req         (arb_req),
        .last_winner (last_winner_q),
        .gnt         (arb_gnt),
        .winner      (winner)
    );

    assign win_addr  = (winner == REQ_LS) ? bus.ls_addr : bus.if_addr;
    assign accept    = (state_q == IDLE) && (arb_req != 2'b00);
    assign resp_data = err_q ? '0 : bus.mem_rdata;

`ifdef IMEM_ARB_ERR_CHECK_EN
    assign win_fault = addr_faults(int'({{(32-ADDR_W){1'b0}}, win_addr}), MEM_BYTES);
`else
    assign win_fault = 1'b0;
`endif

    // A faulting access parks the memory address at 0 so nothing out of range is read.
    assign bus.mem_addr = addr_q;

    always_comb begin
        state_d       = state_q;
        bus.if_gnt    = 1'b0;
        bus.ls_gnt    = 1'b0;
        bus.if_rvalid = 1'b0;
        bus.ls_rvalid = 1'b0;
        bus.if_err    = 1'b0;
        bus.ls_err    = 1'b0;
        bus.if_rdata  = if_rdata_q;
        bus.ls_rdata  = ls_rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = ISSUE;
                    bus.if_gnt = arb_gnt[0];
                    bus.ls_gnt = arb_gnt[1];
                end
            end
            ISSUE: state_d = RESP;
            RESP: begin
                state_d = IDLE;
                if (owner_q == REQ_IF) begin
                    bus.if_rvalid = 1'b1;
                    bus.if_err    = err_q;
                    bus.if_rdata  = resp_data;
                end else begin
                    bus.ls_rvalid = 1'b1;
                    bus.ls_err    = err_q;
                    bus.ls_rdata  = resp_data;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The response word is captured at the end of RESP so rdata holds while rvalid is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            owner_q       <= REQ_IF;
            last_winner_q <= REQ_LS;
            err_q         <= 1'b0;
            if_rdata_q    <= '0;
            ls_rdata_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q        <= win_fault ? '0 : win_addr;
                owner_q       <= winner;
                last_winner_q <= winner;
                err_q         <= win_fault;
            end
            if (state_q == RESP) begin
                if (owner_q == REQ_IF) begin
                    if_rdata_q <= resp_data;
                end else begin
                    ls_rdata_q <= resp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Directed self-checking bench for imem_port_arbiter with a byte-array memory model.
// Expected error results follow IMEM_ARB_ERR_CHECK_EN when it is defined.
module tb_imem_port_arbiter;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    logic [7:0] mem [0:63];

    imem_port_arbiter_if bus ();

    imem_port_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read big-endian memory, address wraps at 6 bits.
    always @(posedge clk) begin
        bus.mem_rdata <= {mem[bus.mem_addr], mem[bus.mem_addr + 6'd1],
                          mem[bus.mem_addr + 6'd2], mem[bus.mem_addr + 6'd3]};
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n       = 1'b0;
        bus.if_req  = 1'b0;
        bus.ls_req  = 1'b0;
        bus.if_addr = '0;
        bus.ls_addr = '0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        tests_run++;
        if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.if_err, bus.ls_err} !== 6'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 000000",
                     {bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid, bus.if_err, bus.ls_err});
        end
        tests_run++;
        if ({bus.if_rdata, bus.ls_rdata} !== 64'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", bus.if_rdata, bus.ls_rdata);
        end
        tests_run++;
        if (bus.mem_addr !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_if_only();
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 6'd4;
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b1 || bus.ls_gnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL if_only_gnt: got if=%b ls=%b expected if=1 ls=0", bus.if_gnt, bus.ls_gnt);
        end
        next_cycle();
        bus.if_req = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_addr !== 6'd4 || bus.if_gnt !== 1'b0 || bus.if_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL if_only_issue: got addr=%0d gnt=%b rvalid=%b expected 4/0/0",
                     bus.mem_addr, bus.if_gnt, bus.if_rvalid);
        end
        next_cycle();
        #1;
        tests_run++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h12345678 || bus.if_err !== 1'b0 || bus.ls_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL if_only_resp: got rv=%b data=%h err=%b ls_rv=%b expected 1/12345678/0/0",
                     bus.if_rvalid, bus.if_rdata, bus.if_err, bus.ls_rvalid);
        end
        next_cycle();
        #1;
        tests_run++;
        if (bus.if_rvalid !== 1'b0 || bus.if_rdata !== 32'h12345678) begin
            tests_failed++;
            $display("[TB] FAIL if_only_hold: got rv=%b data=%h expected 0/12345678", bus.if_rvalid, bus.if_rdata);
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_if_gnt, exp_ls_gnt, exp_if_rv, exp_ls_rv;
        logic [31:0] exp_data, got_data;
        do_reset();
        bus.if_req  = 1'b1;
        bus.if_addr = 6'd0;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 6'd8;
        for (int k = 0; k < 12; k++) begin
            exp_if_gnt = (k % 3 == 0) && ((k / 3) % 2 == 0);
            exp_ls_gnt = (k % 3 == 0) && ((k / 3) % 2 == 1);
            exp_if_rv  = (k % 3 == 2) && ((k / 3) % 2 == 0);
            exp_ls_rv  = (k % 3 == 2) && ((k / 3) % 2 == 1);
            #1;
            tests_run++;
            if ({bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid} !== {exp_if_gnt, exp_ls_gnt, exp_if_rv, exp_ls_rv}) begin
                tests_failed++;
                $display("[TB] FAIL b2b_ctrl[%0d]: got gnt=%b%b rv=%b%b expected gnt=%b%b rv=%b%b", k,
                         bus.if_gnt, bus.ls_gnt, bus.if_rvalid, bus.ls_rvalid,
                         exp_if_gnt, exp_ls_gnt, exp_if_rv, exp_ls_rv);
            end
            if (k % 3 == 2) begin
                exp_data = exp_if_rv ? 32'hA0A1A2A3 : 32'hA8A9AAAB;
                got_data = exp_if_rv ? bus.if_rdata : bus.ls_rdata;
                tests_run++;
                if (got_data !== exp_data) begin
                    tests_failed++;
                    $display("[TB] FAIL b2b_data[%0d]: got %h expected %h", k, got_data, exp_data);
                end
            end
            next_cycle();
        end
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
    endtask

    task automatic test_req_during_resp();
        do_reset();
        bus.ls_req  = 1'b1;
        bus.ls_addr = 6'd12;
        #1;
        tests_run++;
        if (bus.ls_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL resp_req_ls_gnt: got ls=%b if=%b expected 1/0", bus.ls_gnt, bus.if_gnt);
        end
        next_cycle();
        bus.ls_req = 1'b0;
        #1;
        tests_run++;
        if (bus.mem_addr !== 6'd12) begin
            tests_failed++;
            $display("[TB] FAIL resp_req_mem_addr: got %0d expected 12", bus.mem_addr);
        end
        next_cycle();
        bus.if_req  = 1'b1;
        bus.if_addr = 6'd0;
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b0 || bus.ls_rvalid !== 1'b1 || bus.ls_rdata !== 32'hACADAEAF) begin
            tests_failed++;
            $display("[TB] FAIL resp_req_in_resp: got if_gnt=%b ls_rv=%b data=%h expected 0/1/acadaeaf",
                     bus.if_gnt, bus.ls_rvalid, bus.ls_rdata);
        end
        next_cycle();
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL resp_req_if_gnt: got %b expected 1", bus.if_gnt);
        end
        next_cycle();
        bus.if_req = 1'b0;
        next_cycle();
        #1;
        tests_run++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA0A1A2A3 || bus.ls_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL resp_req_if_resp: got rv=%b data=%h ls_rv=%b expected 1/a0a1a2a3/0",
                     bus.if_rvalid, bus.if_rdata, bus.ls_rvalid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.ls_req  = 1'b1;
        bus.ls_addr = 6'd8;
        #1;
        tests_run++;
        if (bus.ls_gnt !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL mid_rst_gnt: got %b expected 1", bus.ls_gnt);
        end
        next_cycle();
        bus.ls_req = 1'b0;
        rst_n      = 1'b0;
        next_cycle();
        #1;
        tests_run++;
        if (bus.ls_rvalid !== 1'b0 || bus.mem_addr !== 6'd0) begin
            tests_failed++;
            $display("[TB] FAIL mid_rst_drop: got ls_rv=%b addr=%0d expected 0/0", bus.ls_rvalid, bus.mem_addr);
        end
        rst_n       = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 6'd0;
        bus.ls_req  = 1'b1;
        bus.ls_addr = 6'd8;
        #1;
        tests_run++;
        if (bus.if_gnt !== 1'b1 || bus.ls_gnt !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_rst_tie: got if=%b ls=%b expected 1/0", bus.if_gnt, bus.ls_gnt);
        end
        next_cycle();
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
        next_cycle();
        #1;
        tests_run++;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA0A1A2A3 || bus.ls_rvalid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_rst_resp: got rv=%b data=%h ls_rv=%b expected 1/a0a1a2a3/0",
                     bus.if_rvalid, bus.if_rdata, bus.ls_rvalid);
        end
    endtask

    task automatic test_err_check();
        logic [5:0]  addr, exp_mem_addr;
        logic        exp_err;
        logic [31:0] exp_data;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            case (i)
`ifdef IMEM_ARB_ERR_CHECK_EN
                0:       begin addr = 6'd6;  exp_mem_addr = 6'd0;  exp_err = 1'b1; exp_data = 32'h0; end
                1:       begin addr = 6'd48; exp_mem_addr = 6'd0;  exp_err = 1'b1; exp_data = 32'h0; end
`else
                0:       begin addr = 6'd6;  exp_mem_addr = 6'd6;  exp_err = 1'b0; exp_data = 32'h5678A8A9; end
                1:       begin addr = 6'd48; exp_mem_addr = 6'd48; exp_err = 1'b0; exp_data = 32'hD0D1D2D3; end
`endif
                default: begin addr = 6'd44; exp_mem_addr = 6'd44; exp_err = 1'b0; exp_data = 32'hCCCDCECF; end
            endcase
            bus.ls_req  = 1'b1;
            bus.ls_addr = addr;
            #1;
            tests_run++;
            if (bus.ls_gnt !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL err_gnt[%0d]: got %b expected 1", addr, bus.ls_gnt);
            end
            next_cycle();
            bus.ls_req = 1'b0;
            #1;
            tests_run++;
            if (bus.mem_addr !== exp_mem_addr) begin
                tests_failed++;
                $display("[TB] FAIL err_mem_addr[%0d]: got %0d expected %0d", addr, bus.mem_addr, exp_mem_addr);
            end
            next_cycle();
            #1;
            tests_run++;
            if (bus.ls_rvalid !== 1'b1 || bus.ls_err !== exp_err || bus.ls_rdata !== exp_data) begin
                tests_failed++;
                $display("[TB] FAIL err_resp[%0d]: got rv=%b err=%b data=%h expected 1/%b/%h",
                         addr, bus.ls_rvalid, bus.ls_err, bus.ls_rdata, exp_err, exp_data);
            end
            next_cycle();
        end
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.if_req    = 1'b0;
        bus.ls_req    = 1'b0;
        bus.if_addr   = '0;
        bus.ls_addr   = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'hA0 + 8'(i);
        end
        mem[4] = 8'h12;
        mem[5] = 8'h34;
        mem[6] = 8'h56;
        mem[7] = 8'h78;

        test_reset();
        test_if_only();
        test_back_to_back();
        test_req_during_resp();
        test_reset_mid();
        test_err_check();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
